camera_capture_ctrl: RTL and testbench
======================================

// Module: camera_capture_ctrl
// PURPOSE
//   Sequences capture of one OV7670 RGB565 frame after SCCB configuration has finished.
//   Samples PIXEL/VSYNC/HREF/PCLK in the GLOBAL_CLK domain.
//   Pairs bytes into 16-bit pixels and drives a linear write port into the SPRAM frame buffer.
//   Sits between the camera pins / CAMERA_CONTROLLER and the frame-buffer memory.
// PARAMETERS
//   H_ACTIVE     160   pixels (16-bit words) per line; 2*H_ACTIVE bytes per line.
//   V_ACTIVE     120   lines per frame.
//   ADDR_W       15    width of WR_ADDR; H_ACTIVE*V_ACTIVE <= 2**ADDR_W.
//   SYNC_STAGES  2     flip-flop stages on PIXEL, VSYNC, HREF and PCLK; all inputs use equal depth.
// PORTS
//   GLOBAL_CLK       in   1       system clock; PCLK <= GLOBAL_CLK/4 by camera configuration.
//   RESET            in   1       asynchronous, active-high reset.
//   CONFIG_FINISHED  in   1       level from CAMERA_CONTROLLER; capture is allowed only while high.
//   START            in   1       one-cycle request to capture one frame.
//   PIXEL            in   8       camera data byte.
//   VSYNC            in   1       camera frame sync; high = vertical blanking.
//   HREF             in   1       camera line-valid signal.
//   PCLK             in   1       camera pixel clock, treated as data.
//   WR_EN            out  1       frame-buffer write strobe, one cycle per pixel.
//   WR_ADDR          out  ADDR_W  write address: line*H_ACTIVE + pixel.
//   WR_DATA          out  16      RGB565 pixel; first byte of the pair is [15:8].
//   BUSY             out  1       high in any state other than IDLE.
//   FRAME_DONE       out  1       one-cycle pulse when the frame ends.
//   ERROR            out  1       sticky geometry error; cleared on the next accepted START.
// BEHAVIOUR
//   Reset values: all outputs 0, FSM in IDLE, all counters 0, byte phase 0.
//     RESET mid-frame aborts immediately; no FRAME_DONE is issued.
//   Synchronisation and edge detection:
//     Every input passes through SYNC_STAGES flip-flops.
//     pclk_rise = sync PCLK high AND previous sync PCLK low.
//     Edges are also detected for sync VSYNC and sync HREF.
//   FSM:
//     IDLE       -> ARM when START && CONFIG_FINISHED; clear ERROR and all counters.
//                   START without CONFIG_FINISHED is ignored.
//     ARM        -> WAIT_FRAME on VSYNC rise, so a partial frame is never captured.
//     WAIT_FRAME -> CAPTURE on VSYNC fall.
//     CAPTURE    -> DONE on VSYNC rise.
//     DONE       -> IDLE after one cycle; FRAME_DONE=1 during DONE.
//     START while BUSY is ignored.
//   Byte capture (CAPTURE only):
//     On pclk_rise with sync HREF=1, latch sync PIXEL and toggle the byte phase.
//     Phase 0 byte goes to WR_DATA[15:8]; phase 1 byte goes to WR_DATA[7:0].
//   Write timing:
//     WR_EN=1 for exactly the cycle after the pclk_rise that captured the phase-1 byte.
//     WR_ADDR and WR_DATA are valid in that cycle.
//     Latency from PCLK pin rise to WR_EN is SYNC_STAGES+2 cycles.
//     The pixel counter increments after the write.
//   Line end (HREF fall):
//     ERROR is set if the line's byte count != 2*H_ACTIVE.
//     Byte phase resets to 0; a dangling odd byte is discarded without a write.
//     The line counter increments, saturating at V_ACTIVE.
//     The line's pixel counter resets to 0.
//   Overrun:
//     Pixels with index >= H_ACTIVE, or in lines with index >= V_ACTIVE, are not written.
//     Each such overrun also sets ERROR.
//     WR_ADDR never exceeds H_ACTIVE*V_ACTIVE-1.
//   Frame end (VSYNC rise in CAPTURE):
//     Any line still open (HREF high) is closed with the line-end checks.
//     ERROR is set if the line count != V_ACTIVE.
//     If HREF falls and VSYNC rises in the same cycle, the line close is processed first.
//   CONFIG_FINISHED fall while BUSY: return to IDLE; no FRAME_DONE; ERROR=1.
// TESTING
//   Nominal frame:
//     Config high, START, then a frame of 120 lines x 320 bytes, PCLK=GLOBAL_CLK/4.
//     Expect 19200 WR_EN pulses, WR_ADDR 0..19199 in order, one FRAME_DONE, ERROR=0.
//   Byte order:
//     Line bytes 0xAB,0xCD,0x12,0x34.
//     Expect writes {0xABCD @0} then {0x1234 @1}; WR_EN exactly SYNC_STAGES+2 cycles after the 2nd PCLK rise.
//   Mid-frame START:
//     START asserted while VSYNC low mid-frame.
//     Expect no WR_EN until the next VSYNC rise then fall; the full next frame is captured.
//   Short line and odd byte:
//     One line of 319 bytes.
//     Expect 159 writes for that line, the odd byte dropped, next line starting at address line*160, ERROR=1.
//   Gating and reset:
//     START with CONFIG_FINISHED=0 -> BUSY stays 0.
//     RESET asserted mid-CAPTURE -> all outputs 0 immediately; the next START captures a clean frame with ERROR=0.
//   Overrun:
//     Frame of 122 lines.
//     Expect no write above address 19199, ERROR=1, FRAME_DONE pulsed once.

Source files
------------

// File: rtl/camera_capture_ctrl.sv
// Captures one OV7670 RGB565 frame into a linear frame buffer once SCCB
// configuration is complete. All camera pins are sampled as data in the
// GLOBAL_CLK domain. Byte pairs are packed into 16-bit pixels and written
// at line*H_ACTIVE + pixel.
module camera_capture_ctrl #(
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 120,
  parameter int ADDR_W      = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic              GLOBAL_CLK,
  input  logic              RESET,
  input  logic              CONFIG_FINISHED,
  input  logic              START,
  input  logic [7:0]        PIXEL,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic              PCLK,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [15:0]       WR_DATA,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              ERROR
);

  localparam int PW = $clog2(H_ACTIVE + 1);
  localparam int BW = $clog2(2 * H_ACTIVE + 2);
  localparam int LW = $clog2(V_ACTIVE + 1);

  localparam logic [PW-1:0]     PIX_MAX   = PW'(H_ACTIVE);
  localparam logic [BW-1:0]     BYTE_LINE = BW'(2 * H_ACTIVE);
  localparam logic [BW-1:0]     BYTE_SAT  = BW'(2 * H_ACTIVE + 1);
  localparam logic [LW-1:0]     LINE_MAX  = LW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Synchroniser stages: {PCLK, VSYNC, HREF, PIXEL} travel together so the
  // byte, the line-valid and the clock edge stay aligned.
  logic [SYNC_STAGES-1:0][10:0] sync_q;
  logic [10:0] sync_s;
  logic        pclk_s, vsync_s, href_s;
  logic [7:0]  pix_s;

  // Edge-detect stage outputs
  logic       pclk_prev_q, vsync_prev_q, href_prev_q;
  logic       pclk_rise_p0_q, vsync_rise_p0_q, vsync_fall_p0_q, href_fall_p0_q;
  logic       href_p0_q;
  logic [7:0] pix_p0_q;

  // Capture state
  logic [2:0]        state_q, state_d;
  logic              err_q, err_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
  logic [BW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [LW-1:0]     line_cnt_q, line_cnt_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;

  logic              cap, line_close;
  logic [BW-1:0]     byte_eff;
  logic [LW-1:0]     line_eff;

  assign sync_s  = sync_q[SYNC_STAGES-1];
  assign pclk_s  = sync_s[10];
  assign vsync_s = sync_s[9];
  assign href_s  = sync_s[8];
  assign pix_s   = sync_s[7:0];

  // Shift the raw camera pins through the synchroniser chain.
  always_ff @(posedge GLOBAL_CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= {PCLK, VSYNC, HREF, PIXEL};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // ---- stage p0: register edges of synchronised PCLK/VSYNC/HREF with the byte
  always_ff @(posedge GLOBAL_CLK or posedge RESET) begin
    if (RESET) begin
      pclk_prev_q     <= 1'b0;
      vsync_prev_q    <= 1'b0;
      href_prev_q     <= 1'b0;
      pclk_rise_p0_q  <= 1'b0;
      vsync_rise_p0_q <= 1'b0;
      vsync_fall_p0_q <= 1'b0;
      href_fall_p0_q  <= 1'b0;
      href_p0_q       <= 1'b0;
      pix_p0_q        <= 8'd0;
    end else begin
      pclk_prev_q     <= pclk_s;
      vsync_prev_q    <= vsync_s;
      href_prev_q     <= href_s;
      pclk_rise_p0_q  <= pclk_s & ~pclk_prev_q;
      vsync_rise_p0_q <= vsync_s & ~vsync_prev_q;
      vsync_fall_p0_q <= ~vsync_s & vsync_prev_q;
      href_fall_p0_q  <= ~href_s & href_prev_q;
      href_p0_q       <= href_s;
      pix_p0_q        <= pix_s;
    end
  end

  // ---- stage p1: frame sequencing, byte pairing, line/frame checks
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    pix_cnt_d   = pix_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    line_cnt_d  = line_cnt_q;
    line_base_d = line_base_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cap         = pclk_rise_p0_q & href_p0_q;
    // A line still open when VSYNC rises is closed here; if HREF fell in the
    // same cycle href_p0_q is already low, so the line closes exactly once.
    line_close  = href_fall_p0_q | (vsync_rise_p0_q & href_p0_q);
    byte_eff    = byte_cnt_q;
    line_eff    = line_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (START && CONFIG_FINISHED) begin
          state_d     = S_ARM;
          err_d       = 1'b0;
          phase_d     = 1'b0;
          pix_cnt_d   = '0;
          byte_cnt_d  = '0;
          line_cnt_d  = '0;
          line_base_d = '0;
        end
      end
      S_ARM: begin
        if (vsync_rise_p0_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (vsync_fall_p0_q) state_d = S_CAPT;
      end
      S_CAPT: begin
        if (cap) begin
          byte_eff = (byte_cnt_q == BYTE_SAT) ? BYTE_SAT : byte_cnt_q + BW'(1);
          if (!phase_q) begin
            hi_d    = pix_p0_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (pix_cnt_q < PIX_MAX && line_cnt_q < LINE_MAX) begin
              wr_en_d   = 1'b1;
              wr_addr_d = line_base_q + ADDR_W'(pix_cnt_q);
              wr_data_d = {hi_q, pix_p0_q};
            end else begin
              err_d = 1'b1;
            end
            if (pix_cnt_q != PIX_MAX) pix_cnt_d = pix_cnt_q + PW'(1);
          end
        end
        byte_cnt_d = byte_eff;
        if (line_close) begin
          if (byte_eff != BYTE_LINE) err_d = 1'b1;
          phase_d    = 1'b0;
          byte_cnt_d = '0;
          pix_cnt_d  = '0;
          if (line_cnt_q != LINE_MAX) begin
            line_eff    = line_cnt_q + LW'(1);
            line_base_d = line_base_q + LINE_STEP;
          end
          line_cnt_d = line_eff;
        end
        if (vsync_rise_p0_q) begin
          if (line_eff != LINE_MAX) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Losing configuration mid-capture abandons the frame.
    if (!CONFIG_FINISHED && state_q != S_IDLE) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      wr_en_d = 1'b0;
    end
  end

  // Register capture state and the write port.
  always_ff @(posedge GLOBAL_CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      err_q       <= 1'b0;
      phase_q     <= 1'b0;
      hi_q        <= 8'd0;
      pix_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      line_cnt_q  <= '0;
      line_base_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      pix_cnt_q   <= pix_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      line_cnt_q  <= line_cnt_d;
      line_base_q <= line_base_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign WR_EN      = wr_en_q;
  assign WR_ADDR    = wr_addr_q;
  assign WR_DATA    = wr_data_q;
  assign BUSY       = (state_q != S_IDLE);
  assign FRAME_DONE = (state_q == S_DONE);
  assign ERROR      = err_q;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Bench for camera_capture_ctrl: drives synthetic OV7670 frames with random
// pixel bytes and compares every write against an expectation queue built
// from the frame geometry.
module tb_camera_capture_ctrl;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int S  = 2;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          RESET, CONFIG_FINISHED, START, VSYNC, HREF, PCLK;
  logic [7:0]    PIXEL;
  logic          WR_EN, BUSY, FRAME_DONE, ERROR;
  logic [AW-1:0] WR_ADDR;
  logic [15:0]   WR_DATA;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        cur_e;
  int         obs_addr[$];
  int         obs_data[$];
  int         obs_cyc[$];
  int         line_len[$];
  logic [7:0] first_bytes[$];
  int         rise2_cyc = 0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;

  camera_capture_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .SYNC_STAGES(S)
  ) dut (
    .GLOBAL_CLK(clk), .RESET(RESET), .CONFIG_FINISHED(CONFIG_FINISHED),
    .START(START), .PIXEL(PIXEL), .VSYNC(VSYNC), .HREF(HREF), .PCLK(PCLK),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .BUSY(BUSY),
    .FRAME_DONE(FRAME_DONE), .ERROR(ERROR)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Every write is matched against the next expected pixel, including its
  // latency from the PCLK pin rise that delivered the second byte.
  initial forever begin
    @(negedge clk);
    if (!RESET) begin
      if (WR_EN) begin
        obs_addr.push_back(int'(WR_ADDR));
        obs_data.push_back(int'(WR_DATA));
        obs_cyc.push_back(cyc);
        chk("wr_expected", exp_q.size() > 0, 1);
        chk("wr_addr_range", int'(WR_ADDR) <= H * V - 1, 1);
        if (exp_q.size() > 0) begin
          cur_e = exp_q.pop_front();
          chk("wr_addr", WR_ADDR, cur_e.addr);
          chk("wr_data", WR_DATA, cur_e.data);
          chk("wr_latency", cyc - cur_e.cyc, S + 2);
        end
      end
      if (FRAME_DONE) done_cnt++;
    end
  end

  task automatic pulse_start();
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
  endtask

  // Request a capture and present a VSYNC rise so the next frame is taken.
  task automatic arm();
    pulse_start();
    VSYNC = 1'b0;
    repeat (8) @(negedge clk);
    VSYNC = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic set_lines(input int n, input int len);
    line_len.delete();
    for (int i = 0; i < n; i++) line_len.push_back(len);
  endtask

  // Drive one frame (VSYNC high on entry and exit). PCLK = clk/4, data
  // changes while PCLK is low. Optionally pulse START or RESET mid-frame.
  task automatic drive_frame(input bit capture, input int start_line, input int reset_line);
    int         nl, k, d0, exp_err;
    bit         cap;
    logic [7:0] v, hi;
    cap     = capture;
    nl      = line_len.size();
    exp_err = 0;
    hi      = 8'd0;
    d0      = done_cnt;
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    repeat (8) @(negedge clk);
    VSYNC = 1'b0;
    repeat (8) @(negedge clk);
    for (int l = 0; l < nl; l++) begin
      if (l == start_line) pulse_start();
      for (int b = 0; b < line_len[l]; b++) begin
        if (l == 0 && b < first_bytes.size()) v = first_bytes[b];
        else v = 8'($urandom_range(0, 255));
        PIXEL = v;
        HREF  = 1'b1;
        PCLK  = 1'b0;
        repeat (2) @(negedge clk);
        PCLK = 1'b1;
        if (b % 2 == 0) begin
          hi = v;
        end else begin
          k = b / 2;
          if (l == 0 && b == 1) rise2_cyc = cyc;
          if (k < H && l < V) begin
            if (cap) exp_q.push_back('{l * H + k, int'({hi, v}), cyc});
          end else begin
            exp_err = 1;
          end
        end
        repeat (2) @(negedge clk);
        if (l == reset_line && b == 5) begin
          RESET = 1'b1;
          #1;
          chk("rst_wr_en", WR_EN, 0);
          chk("rst_wr_addr", WR_ADDR, 0);
          chk("rst_wr_data", WR_DATA, 0);
          chk("rst_busy", BUSY, 0);
          chk("rst_frame_done", FRAME_DONE, 0);
          chk("rst_error", ERROR, 0);
          exp_q.delete();
          cap = 1'b0;
          @(negedge clk);
          RESET = 1'b0;
        end
      end
      PCLK = 1'b0;
      HREF = 1'b0;
      if (line_len[l] != 2 * H) exp_err = 1;
      repeat (8) @(negedge clk);
    end
    if (((nl < V) ? nl : V) != V) exp_err = 1;
    repeat (4) @(negedge clk);
    VSYNC = 1'b1;
    repeat (12) @(negedge clk);
    if (cap) begin
      chk("frame_pending_writes", exp_q.size(), 0);
      chk("frame_error", ERROR, exp_err);
      chk("frame_done_count", done_cnt - d0, 1);
      chk("frame_busy_after", BUSY, 0);
    end else begin
      chk("no_frame_done", done_cnt - d0, 0);
    end
  endtask

  initial begin
    int nl;
    RESET = 1'b1; CONFIG_FINISHED = 1'b0; START = 1'b0; VSYNC = 1'b0;
    HREF = 1'b0; PCLK = 1'b0; PIXEL = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_wr_en", WR_EN, 0);
    chk("reset_wr_addr", WR_ADDR, 0);
    chk("reset_wr_data", WR_DATA, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_frame_done", FRAME_DONE, 0);
    chk("reset_error", ERROR, 0);
    RESET = 1'b0;
    repeat (2) @(negedge clk);

    // START is ignored without configuration
    pulse_start();
    repeat (4) @(negedge clk);
    chk("gated_busy", BUSY, 0);
    CONFIG_FINISHED = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal frame
    set_lines(V, 2 * H);
    arm();
    drive_frame(1'b1, -1, -1);
    chk("nominal_write_count", obs_addr.size(), H * V);
    if (obs_addr.size() == H * V) chk("nominal_last_addr", obs_addr[H * V - 1], 47);

    // Byte order and pin-to-write latency
    first_bytes = '{8'hAB, 8'hCD, 8'h12, 8'h34};
    arm();
    drive_frame(1'b1, -1, -1);
    first_bytes.delete();
    chk("order_count_ge2", obs_addr.size() >= 2, 1);
    if (obs_addr.size() >= 2) begin
      chk("order_addr0", obs_addr[0], 0);
      chk("order_data0", obs_data[0], 16'hABCD);
      chk("order_addr1", obs_addr[1], 1);
      chk("order_data1", obs_data[1], 16'h1234);
      chk("order_latency", obs_cyc[0] - rise2_cyc, 4);
    end

    // START mid-frame: that frame is skipped, the following one captured
    drive_frame(1'b0, 2, -1);
    drive_frame(1'b1, -1, -1);
    chk("midstart_next_count", obs_addr.size(), H * V);

    // Short line with a dangling odd byte
    set_lines(V, 2 * H);
    line_len[3] = 2 * H - 1;
    arm();
    drive_frame(1'b1, -1, -1);
    chk("short_write_count", obs_addr.size(), 47);
    if (obs_addr.size() > 31) chk("short_next_line_addr", obs_addr[31], 32);
    chk("short_error", ERROR, 1);

    // Reset mid-capture, then a clean frame
    set_lines(V, 2 * H);
    arm();
    drive_frame(1'b1, -1, 2);
    arm();
    drive_frame(1'b1, -1, -1);
    chk("post_reset_error", ERROR, 0);

    // Randomised geometry
    for (int f = 0; f < 3; f++) begin
      nl = $urandom_range(V - 1, V + 1);
      line_len.delete();
      for (int l = 0; l < nl; l++) begin
        case ($urandom_range(0, 5))
          0:       line_len.push_back(2 * H - 1);
          1:       line_len.push_back(2 * H + 2);
          2:       line_len.push_back(2 * H - 4);
          default: line_len.push_back(2 * H);
        endcase
      end
      arm();
      drive_frame(1'b1, -1, -1);
    end

    // Configuration lost while busy
    begin
      int d0;
      d0 = done_cnt;
      pulse_start();
      chk("cfgdrop_busy_before", BUSY, 1);
      CONFIG_FINISHED = 1'b0;
      repeat (2) @(negedge clk);
      chk("cfgdrop_busy", BUSY, 0);
      chk("cfgdrop_error", ERROR, 1);
      chk("cfgdrop_no_done", done_cnt - d0, 0);
      CONFIG_FINISHED = 1'b1;
      repeat (2) @(negedge clk);
    end

    // Overrun: two extra lines
    set_lines(V + 2, 2 * H);
    arm();
    drive_frame(1'b1, -1, -1);
    chk("overrun_write_count", obs_addr.size(), H * V);
    chk("overrun_error", ERROR, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
